// File: rtl/hazard_pkg.sv
// Shared encodings for the pipeline hazard unit: forwarding selects, the
// mult/div occupancy FSM states, and the operand-select priority helper.
package hazard_pkg;

  localparam int CNT_W = 8;

  typedef enum logic [1:0] {
    SEL_RF = 2'd0,
    SEL_MX = 2'd1,
    SEL_WX = 2'd2
  } fwd_sel_e;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } md_state_e;

  // The younger producer (the op about to sit in M) wins over the older one.
  function automatic fwd_sel_e pick_sel(input logic rd_en, input logic hit_x,
                                        input logic hit_m);
    if (!rd_en) return SEL_RF;
    if (hit_x)  return SEL_MX;
    if (hit_m)  return SEL_WX;
    return SEL_RF;
  endfunction

endpackage

// File: rtl/hazard_tag_stage.sv
// One pipeline tag register: loads d when enabled, loads an all-zero bubble
// when enabled with bubble set, and otherwise holds its contents.
module hazard_tag_stage
  import hazard_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clock,
  input  logic         reset_n,
  input  logic         en,
  input  logic         bubble,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] tag_d;
  logic [W-1:0] tag_q;

  // NOTE: tag_d gets its hold value first so every path assigns it and no latch is inferred.
  always_comb begin
    tag_d = tag_q;
    if (en) tag_d = bubble ? '0 : d;
  end

  // NOTE: the tag is reset as a whole, not just its valid bit, so selects and
  // indices never carry X into the comparators after reset.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) tag_q <= '0;
    else          tag_q <= tag_d;
  end

  assign q = tag_q;

endmodule

// File: rtl/hazard_unit.sv
// Hazard detection and forwarding control for a 5-stage pipeline with a
// multi-cycle mult/div unit that occupies X for MD_LATENCY cycles.
module hazard_unit
  import hazard_pkg::*;
#(
  parameter int REG_W      = 5,
  parameter int MD_LATENCY = 32,
  parameter int STATUS_REG = 30
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             id_valid,
  input  logic [REG_W-1:0] id_rs1,
  input  logic [REG_W-1:0] id_rs2,
  input  logic             id_rs1_en,
  input  logic             id_rs2_en,
  input  logic [REG_W-1:0] id_rd,
  input  logic             id_wr_en,
  input  logic             id_wr_status,
  input  logic             id_is_load,
  input  logic             id_is_store,
  input  logic             id_is_md,
  input  logic             flush,
  output logic             stall,
  output logic [1:0]       fwd_a_sel,
  output logic [1:0]       fwd_b_sel,
  output logic             wm_fwd,
  output logic             md_busy
);

  typedef struct packed {
    logic             valid;
    logic [REG_W-1:0] rd;
    logic             wr_en;
    logic             wr_status;
    logic             is_load;
    logic             is_store;
    logic [REG_W-1:0] rs2;
    fwd_sel_e         sel_a;
    fwd_sel_e         sel_b;
  } tag_t;

  localparam int TAG_W = $bits(tag_t);

  tag_t             d_tag;
  tag_t             x_q;
  tag_t             m_q;
  tag_t             w_q;
  md_state_e        state_d, state_q;
  logic [CNT_W-1:0] cnt_d, cnt_q;
  logic             busy;
  logic             hold_x;
  logic             load_use;
  logic             d_ok;

  // Register 0 is hard-wired, so it never creates a dependency.
  function automatic logic writes(input tag_t t, input logic [REG_W-1:0] r);
    return t.valid && (r != '0) &&
           ((t.wr_en && (t.rd == r)) || (t.wr_status && (r == REG_W'(STATUS_REG))));
  endfunction

  always_comb begin
    busy   = (state_q == BUSY);
    hold_x = busy && (cnt_q != '0);

    // A store only needs rs2 in M, where W can still supply the loaded data.
    load_use = id_valid && x_q.valid && x_q.is_load &&
               ((id_rs1_en && writes(x_q, id_rs1)) ||
                (id_rs2_en && !id_is_store && writes(x_q, id_rs2)));

    stall = busy || (load_use && !flush);
    d_ok  = id_valid && !flush && !stall;

    d_tag           = '0;
    d_tag.valid     = 1'b1;
    d_tag.rd        = id_rd;
    d_tag.wr_en     = id_wr_en;
    d_tag.wr_status = id_wr_status;
    d_tag.is_load   = id_is_load;
    d_tag.is_store  = id_is_store;
    d_tag.rs2       = id_rs2;
    d_tag.sel_a     = pick_sel(id_rs1_en, writes(x_q, id_rs1), writes(m_q, id_rs1));
    d_tag.sel_b     = pick_sel(id_rs2_en, writes(x_q, id_rs2), writes(m_q, id_rs2));
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (d_ok && id_is_md) begin
          state_d = BUSY;
          cnt_d   = CNT_W'(MD_LATENCY - 1);
        end
      end
      BUSY: begin
        if (cnt_q == '0) state_d = IDLE;
        else             cnt_d   = cnt_q - CNT_W'(1);
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state flops use non-blocking assignments so every register samples
  // pre-edge values regardless of process ordering.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // While the md op is counting down it stays in X and M receives bubbles;
  // on its last cycle it moves on to M and X takes the stall bubble.
  hazard_tag_stage #(.W(TAG_W)) u_x_stage (
    .clock  (clock),
    .reset_n(reset_n),
    .en     (!hold_x),
    .bubble (!d_ok),
    .d      (d_tag),
    .q      (x_q)
  );

  hazard_tag_stage #(.W(TAG_W)) u_m_stage (
    .clock  (clock),
    .reset_n(reset_n),
    .en     (1'b1),
    .bubble (hold_x),
    .d      (x_q),
    .q      (m_q)
  );

  hazard_tag_stage #(.W(TAG_W)) u_w_stage (
    .clock  (clock),
    .reset_n(reset_n),
    .en     (1'b1),
    .bubble (1'b0),
    .d      (m_q),
    .q      (w_q)
  );

  assign fwd_a_sel = x_q.sel_a;
  assign fwd_b_sel = x_q.sel_b;
  assign md_busy   = busy;
  assign wm_fwd    = m_q.valid && m_q.is_store && (m_q.rs2 != '0) && writes(w_q, m_q.rs2);

  // Tag fields carried down the pipe but not consulted in every stage.
  logic unused_tag_bits;
  assign unused_tag_bits = ^{x_q.is_store, x_q.rs2, m_q.is_load, m_q.sel_a, m_q.sel_b,
                             w_q.is_load, w_q.is_store, w_q.rs2, w_q.sel_a, w_q.sel_b};

endmodule
